// File: rtl/atm_pkg.sv
// Shared types and record-layout helpers for the card session controller and
// the transaction logic that consumes the same account records.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_PIN_WAIT = 3'd3,
        ST_AUTH     = 3'd4,
        ST_WRITE    = 3'd5
    } state_t;

    localparam int DEF_ACC_W     = 16;
    localparam int DEF_PIN_W     = 4;
    localparam int DEF_RSV_W     = 1;
    localparam int DEF_BAL_W     = 10;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_MAX_TRIES = 3;

    // Record layout, MSB to LSB: {unlocked, account, pin, rsv, balance}
    function automatic int rec_width(input int acc_w, input int pin_w,
                                     input int rsv_w, input int bal_w);
        return 1 + acc_w + pin_w + rsv_w + bal_w;
    endfunction

    function automatic int bal_lsb();
        return 0;
    endfunction

    function automatic int rsv_lsb(input int bal_w);
        return bal_w;
    endfunction

    function automatic int pin_lsb(input int rsv_w, input int bal_w);
        return rsv_w + bal_w;
    endfunction

    function automatic int acc_lsb(input int pin_w, input int rsv_w, input int bal_w);
        return pin_w + rsv_w + bal_w;
    endfunction

    function automatic int unlock_bit(input int acc_w, input int pin_w,
                                      input int rsv_w, input int bal_w);
        return acc_w + pin_w + rsv_w + bal_w;
    endfunction

    localparam int DEF_REC_W = rec_width(DEF_ACC_W, DEF_PIN_W, DEF_RSV_W, DEF_BAL_W);

endpackage

// File: rtl/card_session_ctrl_if.sv
// Account RAM bus between the session controller (master) and the RAM (slave).
interface card_session_ctrl_if
    import atm_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REC_W  = DEF_REC_W
);
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [REC_W-1:0]  ram_wdata;
    logic [REC_W-1:0]  ram_rdata;

    modport master (
        output ram_rd_en,
        output ram_wr_en,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_rd_en,
        input  ram_wr_en,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/acc_record_codec.sv
// Combinational pack/unpack of an account record; shared with the transaction
// logic so both sides agree on the field layout.
module acc_record_codec
    import atm_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int PIN_W = DEF_PIN_W,
    parameter int RSV_W = DEF_RSV_W,
    parameter int BAL_W = DEF_BAL_W,
    parameter int REC_W = rec_width(ACC_W, PIN_W, RSV_W, BAL_W)
) (
    input  logic [REC_W-1:0] rd_rec,
    output logic             rd_unlocked,
    output logic [ACC_W-1:0] rd_account,
    output logic [PIN_W-1:0] rd_pin,
    output logic [RSV_W-1:0] rd_rsv,
    output logic [BAL_W-1:0] rd_balance,

    input  logic             wr_unlocked,
    input  logic [ACC_W-1:0] wr_account,
    input  logic [PIN_W-1:0] wr_pin,
    input  logic [RSV_W-1:0] wr_rsv,
    input  logic [BAL_W-1:0] wr_balance,
    output logic [REC_W-1:0] wr_rec
);
    localparam int UNLOCK_BIT = unlock_bit(ACC_W, PIN_W, RSV_W, BAL_W);
    localparam int ACC_LSB    = acc_lsb(PIN_W, RSV_W, BAL_W);
    localparam int PIN_LSB    = pin_lsb(RSV_W, BAL_W);
    localparam int RSV_LSB    = rsv_lsb(BAL_W);
    localparam int BAL_LSB    = bal_lsb();

    assign rd_unlocked = rd_rec[UNLOCK_BIT];
    assign rd_account  = rd_rec[ACC_LSB +: ACC_W];
    assign rd_pin      = rd_rec[PIN_LSB +: PIN_W];
    assign rd_rsv      = rd_rec[RSV_LSB +: RSV_W];
    assign rd_balance  = rd_rec[BAL_LSB +: BAL_W];

    assign wr_rec = {wr_unlocked, wr_account, wr_pin, wr_rsv, wr_balance};
endmodule

// File: rtl/card_session_ctrl.sv
// Card session controller: fetches and verifies the account record on a scan,
// runs PIN entry with bounded retries and writes the record back on change.
module card_session_ctrl
    import atm_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int PIN_W     = DEF_PIN_W,
    parameter int RSV_W     = DEF_RSV_W,
    parameter int BAL_W     = DEF_BAL_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_TRIES = DEF_MAX_TRIES,
    localparam int REC_W    = rec_width(ACC_W, PIN_W, RSV_W, BAL_W),
    localparam int CNT_W    = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              card_scanned,
    input  logic [ACC_W-1:0]  account,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic              pin_valid,
    input  logic [PIN_W-1:0]  pin_entry,
    input  logic              bal_we,
    input  logic [BAL_W-1:0]  new_balance,
    input  logic              session_end,
    card_session_ctrl_if.master ram,
    output logic              session_active,
    output logic              authorised,
    output logic              pin_ok,
    output logic              pin_fail,
    output logic              rejected,
    output logic              locked_out,
    output logic [CNT_W-1:0]  attempts_left,
    output logic [BAL_W-1:0]  balance
);
    state_t state, state_next;

    logic [ACC_W-1:0]  acc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rec_unlocked;
    logic [ACC_W-1:0]  rec_account;
    logic [PIN_W-1:0]  rec_pin;
    logic [RSV_W-1:0]  rec_rsv;
    logic [BAL_W-1:0]  rec_bal;
    logic              lock_q;
    logic              end_q;

    logic              rd_unlocked;
    logic [ACC_W-1:0]  rd_account;
    logic [PIN_W-1:0]  rd_pin;
    logic [RSV_W-1:0]  rd_rsv;
    logic [BAL_W-1:0]  rd_balance;
    logic [REC_W-1:0]  rec_word;

    logic do_scan, do_load, do_reject, do_ok, do_fail, do_lock, do_bal, do_clear;

    acc_record_codec #(
        .ACC_W(ACC_W), .PIN_W(PIN_W), .RSV_W(RSV_W), .BAL_W(BAL_W)
    ) u_codec (
        .rd_rec      (ram.ram_rdata),
        .rd_unlocked (rd_unlocked),
        .rd_account  (rd_account),
        .rd_pin      (rd_pin),
        .rd_rsv      (rd_rsv),
        .rd_balance  (rd_balance),
        .wr_unlocked (rec_unlocked),
        .wr_account  (rec_account),
        .wr_pin      (rec_pin),
        .wr_rsv      (rec_rsv),
        .wr_balance  (rec_bal),
        .wr_rec      (rec_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A lockout lingers one cycle in PIN_WAIT (lock_q set) so the write lands after the pulse
    always_comb begin
        state_next = state;
        do_scan    = 1'b0;
        do_load    = 1'b0;
        do_reject  = 1'b0;
        do_ok      = 1'b0;
        do_fail    = 1'b0;
        do_lock    = 1'b0;
        do_bal     = 1'b0;
        do_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (card_scanned) begin
                    do_scan    = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_CHECK;
            ST_CHECK: begin
                if (!rd_unlocked || rd_account != acc_q) begin
                    do_reject  = 1'b1;
                    do_clear   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    do_load    = 1'b1;
                    state_next = ST_PIN_WAIT;
                end
            end
            ST_PIN_WAIT: begin
                if (lock_q) begin
                    state_next = ST_WRITE;
                end else if (session_end) begin
                    do_clear   = 1'b1;
                    state_next = ST_IDLE;
                end else if (pin_valid) begin
                    if (pin_entry == rec_pin) begin
                        do_ok      = 1'b1;
                        state_next = ST_AUTH;
                    end else begin
                        do_fail = 1'b1;
                        do_lock = (attempts_left == CNT_W'(1));
                    end
                end
            end
            ST_AUTH: begin
                if (bal_we) begin
                    do_bal     = 1'b1;
                    state_next = ST_WRITE;
                end else if (session_end) begin
                    do_clear   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (lock_q || end_q || session_end) begin
                    do_clear   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_AUTH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Session datapath: latched scan, working copy of the record, counters and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            addr_q        <= '0;
            rec_unlocked  <= 1'b0;
            rec_account   <= '0;
            rec_pin       <= '0;
            rec_rsv       <= '0;
            rec_bal       <= '0;
            lock_q        <= 1'b0;
            end_q         <= 1'b0;
            attempts_left <= '0;
            balance       <= '0;
            rejected      <= 1'b0;
            pin_ok        <= 1'b0;
            pin_fail      <= 1'b0;
            locked_out    <= 1'b0;
        end else begin
            rejected   <= do_reject;
            pin_ok     <= do_ok;
            pin_fail   <= do_fail;
            locked_out <= do_lock;
            if (do_scan) begin
                acc_q  <= account;
                addr_q <= acc_addr;
            end
            if (do_load) begin
                rec_unlocked  <= rd_unlocked;
                rec_account   <= rd_account;
                rec_pin       <= rd_pin;
                rec_rsv       <= rd_rsv;
                rec_bal       <= rd_balance;
                balance       <= rd_balance;
                attempts_left <= CNT_W'(MAX_TRIES);
            end
            if (do_fail) attempts_left <= attempts_left - CNT_W'(1);
            if (do_lock) begin
                rec_unlocked <= 1'b0;
                lock_q       <= 1'b1;
            end
            if (do_bal) begin
                rec_bal <= new_balance;
                balance <= new_balance;
                end_q   <= session_end;
            end
            if (do_clear) begin
                balance       <= '0;
                attempts_left <= '0;
                lock_q        <= 1'b0;
                end_q         <= 1'b0;
            end
        end
    end

    assign ram.ram_rd_en   = (state == ST_FETCH);
    assign ram.ram_wr_en   = (state == ST_WRITE);
    assign ram.ram_addr    = (state == ST_FETCH || state == ST_WRITE) ? addr_q : '0;
    assign ram.ram_wdata   = (state == ST_WRITE) ? rec_word : '0;
    assign session_active  = (state == ST_PIN_WAIT || state == ST_AUTH || state == ST_WRITE);
    assign authorised      = (state == ST_AUTH || state == ST_WRITE);
endmodule

// File: doc/card_session_ctrl.md
# card_session_ctrl

Parametrised, sequential successor to the combinational card-info check: on a card scan it fetches the account record from the account RAM, verifies account match and unlock status, runs PIN entry with a bounded retry counter, and writes the record back to the RAM on lockout or balance update. It sits between the card/keypad front end and the account RAM, and feeds the transaction logic.

## Interface
- ACC_W, 16, account number width
- PIN_W, 4, PIN width
- RSV_W, 1, reserved field width between PIN and balance
- BAL_W, 10, balance width
- ADDR_W, 5, account RAM address width
- MAX_TRIES, 3, wrong PIN entries allowed before lockout (≥1)
- Record width REC_W = 1+ACC_W+PIN_W+RSV_W+BAL_W; layout MSB→LSB {unlocked, account, pin, rsv, balance}; defaults give 32 bits.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- card_scanned  in  1  scan pulse; sampled only in IDLE
- account  in  ACC_W  account number read from the card, latched with card_scanned
- acc_addr  in  ADDR_W  RAM address of that account, latched with card_scanned
- pin_valid  in  1  one-cycle keypad PIN strobe
- pin_entry  in  PIN_W  entered PIN, qualified by pin_valid
- bal_we  in  1  one-cycle strobe: commit new balance
- new_balance  in  BAL_W  qualified by bal_we
- session_end  in  1  card ejected / user cancel
- ram_rd_en  out  1  RAM read request
- ram_wr_en  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  REC_W  write record
- ram_rdata  in  REC_W  read data, valid exactly 1 cycle after ram_rd_en
- session_active  out  1  high in PIN_WAIT, AUTH, WRITE
- authorised  out  1  high in AUTH and WRITE
- pin_ok, pin_fail, rejected, locked_out  out  1  one-cycle event pulses
- attempts_left  out  $clog2(MAX_TRIES+1)  remaining PIN tries
- balance  out  BAL_W  balance of the open session

## Operation
- States: IDLE, FETCH, CHECK, PIN_WAIT, AUTH, WRITE.
- IDLE: card_scanned → latch account, acc_addr; go FETCH. card_scanned outside IDLE is ignored.
- FETCH: ram_rd_en=1, ram_addr=latched address; go CHECK.
- CHECK: compare ram_rdata account field with latched account. Mismatch or unlocked bit = 0 → rejected pulse, go IDLE. Otherwise latch record, balance←record balance, attempts_left←MAX_TRIES, go PIN_WAIT.
- PIN_WAIT on pin_valid: match → pin_ok, go AUTH. Mismatch → pin_fail, attempts_left−1; if result is 0 → locked_out, ram_wdata=record with unlocked=0, go WRITE (then IDLE).
- AUTH on bal_we: record balance field←new_balance, balance←new_balance, go WRITE.
- WRITE: ram_wr_en=1 for one cycle with ram_addr=latched address; next state AUTH, or IDLE after lockout or a pending session_end.
- session_end in PIN_WAIT or AUTH → IDLE, no write; outputs cleared.
- Priorities: session_end beats pin_valid in PIN_WAIT; bal_we beats session_end in AUTH (write completes, then IDLE).
- Leaving a session (to IDLE) clears balance, attempts_left, session_active and authorised.
- Reserved field and account/PIN fields are written back unchanged.

## Timing
- Reset (async, any state): state IDLE; every output 0, including attempts_left, balance, ram_addr, ram_wdata.
- card_scanned at cycle n → ram_rd_en at n+1 → CHECK at n+2 → rejected pulse or session_active at n+3.
- pin_valid at cycle k → pin_ok/pin_fail at k+1 (registered); locked_out at k+1, ram_wr_en at k+2.
- bal_we at cycle k → balance updated and ram_wr_en at k+1; AUTH resumes at k+2.
- Event pulses are exactly one cycle; ram_rd_en and ram_wr_en are never high together.

## Structure
- Package atm_pkg: state enum, default widths, and field offset localparams/functions (UNLOCK_BIT, ACC_LSB, PIN_LSB, BAL_LSB) derived from the parameters.
- Sub-module acc_record_codec: purely combinational pack/unpack of the record fields, reused by the transaction logic.

## Test plan
- Record {1,0x1234,0x7,0,0x0C8} at addr 3, scan account 0x1234 → rejected=0, session_active, balance=0x0C8, attempts_left=3.
- Same addr, scan account 0x1235 → rejected pulse at n+3; no write; returns to IDLE.
- Three wrong PINs (0x1, 0x2, 0x3) → three pin_fail pulses, attempts_left 2,1,0; locked_out; one write with unlocked=0; a rescan is then rejected.
- Correct PIN 0x7, then bal_we with 0x064 → pin_ok, authorised; one write with balance=0x064; other fields unchanged.
- session_end coincident with pin_valid → no pin_ok/pin_fail, IDLE. bal_we coincident with session_end → write occurs, then IDLE.
- Assert rst mid-PIN_WAIT and during WRITE → all outputs 0 immediately, no further RAM strobes.
